alu_seq: RTL and testbench

Parametrised, handshaked successor to the CPU's 8-bit combinational ALU. It keeps the ADD/AND/NOT opcodes and the carry/zero/overflow/sign flags, and adds SUB/OR/XOR plus two multi-cycle ops: iterative shift-left and shift-add multiply. It sits between the decode/register-read stage and writeback. It accepts one operation at a time over a valid/ready handshake and presents registered results and flags until they are consumed.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_comb.sv | 52 +++++
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (OP_ADD..OP_MUL)
//   - FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE)
//   - flag bundle, packed in the order {carry, zero, overflow, sign}
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
        logic sign;
    } alu_flags_t;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational single-cycle datapath (ADD/AND/NOT/SUB/OR/XOR).
// Ports:
//   opcode  in   operation select
//   a, b    in   operands (WIDTH bits)
//   res     out  result (WIDTH bits)
//   flags   out  {carry, zero, overflow, sign}
// Opcodes outside the single-cycle set produce res=0 with all flags derived
// from that zero result; the caller never uses them.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output alu_flags_t       flags
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Result and flag computation; the extra MSB of sum/diff is carry/borrow.
    always_comb begin
        sum_s          = {1'b0, a} + {1'b0, b};
        diff_s         = {1'b0, a} - {1'b0, b};
        res            = {WIDTH{1'b0}};
        flags.carry    = 1'b0;
        flags.overflow = 1'b0;
        case (opcode)
            OP_ADD: begin
                res            = sum_s[WIDTH-1:0];
                flags.carry    = sum_s[WIDTH];
                flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res            = diff_s[WIDTH-1:0];
                flags.carry    = diff_s[WIDTH];
                flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_NOT:  res = ~a;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            default: res = {WIDTH{1'b0}};
        endcase
        flags.zero = (res == {WIDTH{1'b0}});
        flags.sign = res[WIDTH-1];
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/arithmetic ops and
// iterative SHL (one bit per cycle) and shift-add MUL (WIDTH cycles).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          request handshake; opcode, a, b sampled on accept
//   out_valid/out_ready        result handshake; res and flags held until consumed
//   res                        registered result
//   carry/zero/overflow/sign_flag  registered flags
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             overflow_flag,
    output logic             sign_flag
);

    localparam logic [WIDTH-1:0] WIDTH_OPND = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_max_q, cnt_max_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   res_q, res_d;
    alu_flags_t         flags_q, flags_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   comb_res_s;
    alu_flags_t         comb_flags_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [2*WIDTH-1:0] shl_next_s;
    logic [CNT_W-1:0]   shl_cnt_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [WIDTH-1:0]   fin_res_s;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .res    (comb_res_s),
        .flags  (comb_flags_s)
    );

    // Iterative datapath helpers: MUL adds the multiplicand into the upper half
    // when the product LSB is set, then shifts the whole product right.
    // SHL keeps its operand in the lower half of the product register.
    always_comb begin
        mul_sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, prod_q[WIDTH-1:1]};
        shl_next_s = {{WIDTH{1'b0}}, prod_q[WIDTH-2:0], 1'b0};
        shl_cnt_s  = (b > WIDTH_OPND) ? CNT_FULL : CNT_W'(b);
        cnt_next_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (op_q == OP_MUL) begin
            fin_res_s = mul_next_s[WIDTH-1:0];
        end else begin
            fin_res_s = shl_next_s[WIDTH-1:0];
        end
    end

    // FSM next-state, operand capture and result registration.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        cnt_d       = cnt_q;
        cnt_max_d   = cnt_max_q;
        prod_d      = prod_q;
        res_d       = res_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d  = opcode;
                    a_d   = a;
                    cnt_d = {CNT_W{1'b0}};
                    if (opcode == OP_MUL) begin
                        prod_d    = {{WIDTH{1'b0}}, b};
                        cnt_max_d = CNT_FULL;
                        state_d   = ST_BUSY;
                    end else if ((opcode == OP_SHL) && (b != {WIDTH{1'b0}})) begin
                        prod_d    = {{WIDTH{1'b0}}, a};
                        cnt_max_d = shl_cnt_s;
                        state_d   = ST_BUSY;
                    end else if (opcode == OP_SHL) begin
                        // Zero shift passes a straight through.
                        res_d            = a;
                        flags_d.carry    = 1'b0;
                        flags_d.zero     = (a == {WIDTH{1'b0}});
                        flags_d.overflow = 1'b0;
                        flags_d.sign     = a[WIDTH-1];
                        out_valid_d      = 1'b1;
                        state_d          = ST_DONE;
                    end else begin
                        res_d       = comb_res_s;
                        flags_d     = comb_flags_s;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_next_s;
                if (op_q == OP_MUL) begin
                    prod_d = mul_next_s;
                end else begin
                    prod_d = shl_next_s;
                end
                if (cnt_next_s == cnt_max_q) begin
                    res_d            = fin_res_s;
                    // SHL carry is the bit leaving the top on this final step.
                    flags_d.carry    = (op_q == OP_MUL) ? (|mul_next_s[2*WIDTH-1:WIDTH])
                                                        : prod_q[WIDTH-1];
                    flags_d.zero     = (fin_res_s == {WIDTH{1'b0}});
                    flags_d.overflow = 1'b0;
                    flags_d.sign     = fin_res_s[WIDTH-1];
                    out_valid_d      = 1'b1;
                    state_d          = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            a_q         <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            cnt_max_q   <= {CNT_W{1'b0}};
            prod_q      <= {(2*WIDTH){1'b0}};
            res_q       <= {WIDTH{1'b0}};
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            cnt_q       <= cnt_d;
            cnt_max_q   <= cnt_max_d;
            prod_q      <= prod_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = out_valid_q;
    assign res           = res_q;
    assign carry_flag    = flags_q.carry;
    assign zero_flag     = flags_q.zero;
    assign overflow_flag = flags_q.overflow;
    assign sign_flag     = flags_q.sign;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8). The driver pushes the
// reference result for each accepted operation; an independent monitor
// compares every cycle the DUT shows out_valid and checks latency.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res;
    logic       carry_flag;
    logic       zero_flag;
    logic       overflow_flag;
    logic       sign_flag;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;   // {carry, zero, overflow, sign}
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   seen     = 0;
    bit   rand_bp  = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .a             (a),
        .b             (b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .res           (res),
        .carry_flag    (carry_flag),
        .zero_flag     (zero_flag),
        .overflow_flag (overflow_flag),
        .sign_flag     (sign_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        int ai, bi, r, n;
        logic c, o;
        logic [7:0] rv;
        ai = av; bi = bv; r = 0; c = 1'b0; o = 1'b0;
        e.lat = 1; e.acc = 0;
        case (op)
            3'd0: begin r = ai + bi; c = (r > 255); end
            3'd1: r = ai & bi;
            3'd2: r = ~ai;
            3'd3: begin r = ai - bi; c = (ai < bi); end
            3'd4: r = ai | bi;
            3'd5: r = ai ^ bi;
            3'd6: begin
                n = (bi > 8) ? 8 : bi;
                r = ai << n;
                c = (n > 0) ? (((ai >> (8 - n)) & 1) == 1) : 1'b0;
                e.lat = n + 1;
            end
            default: begin r = ai * bi; c = (r > 255); e.lat = 9; end
        endcase
        rv = r[7:0];
        if (op == 3'd0) o = (av[7] == bv[7]) && (rv[7] != av[7]);
        if (op == 3'd3) o = (av[7] != bv[7]) && (rv[7] != av[7]);
        e.res = rv;
        e.flg = {c, (rv == 8'h00), o, rv[7]};
        return e;
    endfunction

    // Drive one operation and wait (bounded) for it to be accepted.
    task automatic issue(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        int k;
        bit ok;
        @(negedge clk);
        in_valid = 1'b1; opcode = op; a = av; b = bv;
        ok = 0;
        for (k = 0; k < 200; k++) begin
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
            if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: op %0d not accepted within 200 cycles", op);
        end else begin
            e = model(op, av, bv);
            e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: compare outputs against the queue head while out_valid is high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                seen = 0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_output: res %0h with empty scoreboard", res);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        check("latency", cyc - e.acc, e.lat);
                        seen = 1;
                    end
                    check("res", res, e.res);
                    check("flags", {carry_flag, zero_flag, overflow_flag, sign_flag}, e.flg);
                    check("in_ready_low", in_ready, 1'b0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_res"}, res, 8'h00);
        check({tag, "_flags"}, {carry_flag, zero_flag, overflow_flag, sign_flag}, 4'b0000);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [2:0] rop;
        logic [7:0] ra, rb;
        int k;
        rst_n = 1'b0; in_valid = 1'b0; opcode = 3'd0; a = 8'h00; b = 8'h00; out_ready = 1'b1;
        #3;
        check_reset_state("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the operation definitions.
        issue(3'd0, 8'h7F, 8'h01);
        issue(3'd0, 8'hFF, 8'h01);
        issue(3'd3, 8'h05, 8'h07);
        issue(3'd7, 8'h10, 8'h11);
        issue(3'd7, 8'h03, 8'h05);
        issue(3'd6, 8'h81, 8'h01);
        issue(3'd6, 8'h81, 8'h09);
        issue(3'd6, 8'h81, 8'h00);
        issue(3'd6, 8'h81, 8'hFF);
        issue(3'd3, 8'h80, 8'h01);
        issue(3'd2, 8'h55, 8'hAA);

        // Backpressure: result held for 5 cycles while in_valid pulses.
        @(negedge clk);
        out_ready = 1'b0;
        issue(3'd1, 8'hCC, 8'hAA);
        for (k = 0; k < 5; k++) begin
            in_valid = k[0]; opcode = 3'd0; a = 8'h11; b = 8'h22;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;

        // Reset while a MUL is iterating.
        issue(3'd7, 8'hAB, 8'hCD);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(3'd2, 8'h0F, 8'h00);

        // Randomized operations with random consumer backpressure.
        rand_bp = 1;
        for (k = 0; k < 60; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = (rop == 3'd6) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            issue(rop, ra, rb);
        end
        rand_bp = 0;
        out_ready = 1'b1;

        for (k = 0; k < 300; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, 0 expected", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
